// File: rtl/bpsk_mode_ctrl.sv
// bpsk_mode_ctrl: front-panel mode controller for the BPSK modulator.
// Runs the preset/pattern edit menu and commits config over valid/ready.
//
// Ports:
//   clock, reset        : system clock, async active-high reset
//   btn_sel/up/down     : one-cycle press pulses from the debouncers
//   cfg_ready           : modulator accepts the offered config
//   cfg_valid           : config bus holds a new config (COMMIT only)
//   cfg_freq, cfg_pat   : committed/offered preset and pattern index
//   tx_en               : modulator transmit enable, low while editing
//   editing, field      : panel LED and active field (0 freq, 1 pat)

module bpsk_mode_ctrl #(
    parameter int NUM_FREQ = 8,
    parameter int FREQ_W   = 3,
    parameter int NUM_PAT  = 4,
    parameter int PAT_W    = 2,
    parameter int TIMEOUT  = 12_000_000,
    parameter int TO_W     = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_sel,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              cfg_ready,
    output logic              cfg_valid,
    output logic [FREQ_W-1:0] cfg_freq,
    output logic [PAT_W-1:0]  cfg_pat,
    output logic              tx_en,
    output logic              editing,
    output logic              field
);

    typedef enum logic [1:0] {
        RUN,
        EDIT_FREQ,
        EDIT_PAT,
        COMMIT
    } state_t;

    localparam logic [FREQ_W-1:0] FREQ_MAX = FREQ_W'(NUM_FREQ - 1);
    localparam logic [PAT_W-1:0]  PAT_MAX  = PAT_W'(NUM_PAT - 1);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [FREQ_W-1:0] sh_freq, sh_freq_nxt;
    logic [PAT_W-1:0]  sh_pat, sh_pat_nxt;
    logic [TO_W-1:0]   timer, timer_nxt;
    logic              saved_tx, saved_tx_nxt;
    logic              cfg_valid_nxt;
    logic [FREQ_W-1:0] cfg_freq_nxt;
    logic [PAT_W-1:0]  cfg_pat_nxt;
    logic              tx_en_nxt;
    logic              editing_nxt;
    logic              field_nxt;

    logic any_pulse;
    logic step_up;
    logic step_down;

    assign any_pulse = btn_sel | btn_up | btn_down;
    // up and down together cancel; sel overrides both
    assign step_up   = btn_up & ~btn_down & ~btn_sel;
    assign step_down = btn_down & ~btn_up & ~btn_sel;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            sh_freq   <= '0;
            sh_pat    <= '0;
            timer     <= '0;
            saved_tx  <= 1'b0;
            cfg_valid <= 1'b0;
            cfg_freq  <= '0;
            cfg_pat   <= '0;
            tx_en     <= 1'b0;
            editing   <= 1'b0;
            field     <= 1'b0;
        end else begin
            state     <= state_nxt;
            sh_freq   <= sh_freq_nxt;
            sh_pat    <= sh_pat_nxt;
            timer     <= timer_nxt;
            saved_tx  <= saved_tx_nxt;
            cfg_valid <= cfg_valid_nxt;
            cfg_freq  <= cfg_freq_nxt;
            cfg_pat   <= cfg_pat_nxt;
            tx_en     <= tx_en_nxt;
            editing   <= editing_nxt;
            field     <= field_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sh_freq_nxt   = sh_freq;
        sh_pat_nxt    = sh_pat;
        timer_nxt     = timer;
        saved_tx_nxt  = saved_tx;
        cfg_valid_nxt = cfg_valid;
        cfg_freq_nxt  = cfg_freq;
        cfg_pat_nxt   = cfg_pat;
        tx_en_nxt     = tx_en;
        editing_nxt   = editing;
        field_nxt     = field;

        unique case (state)
            RUN: begin
                if (btn_sel) begin
                    state_nxt    = EDIT_FREQ;
                    sh_freq_nxt  = cfg_freq;
                    sh_pat_nxt   = cfg_pat;
                    saved_tx_nxt = tx_en;
                    tx_en_nxt    = 1'b0;
                    editing_nxt  = 1'b1;
                    field_nxt    = 1'b0;
                    timer_nxt    = '0;
                end
            end

            EDIT_FREQ, EDIT_PAT: begin
                if (any_pulse) begin
                    timer_nxt = '0;
                    if (btn_sel) begin
                        if (state == EDIT_FREQ) begin
                            state_nxt = EDIT_PAT;
                            field_nxt = 1'b1;
                        end else begin
                            state_nxt     = COMMIT;
                            cfg_freq_nxt  = sh_freq;
                            cfg_pat_nxt   = sh_pat;
                            cfg_valid_nxt = 1'b1;
                            editing_nxt   = 1'b0;
                            field_nxt     = 1'b0;
                        end
                    end else if (state == EDIT_FREQ) begin
                        if (step_up) begin
                            sh_freq_nxt = (sh_freq == FREQ_MAX) ? '0
                                        : sh_freq + FREQ_W'(1);
                        end else if (step_down) begin
                            sh_freq_nxt = (sh_freq == '0) ? FREQ_MAX
                                        : sh_freq - FREQ_W'(1);
                        end
                    end else begin
                        if (step_up) begin
                            sh_pat_nxt = (sh_pat == PAT_MAX) ? '0
                                       : sh_pat + PAT_W'(1);
                        end else if (step_down) begin
                            sh_pat_nxt = (sh_pat == '0) ? PAT_MAX
                                       : sh_pat - PAT_W'(1);
                        end
                    end
                end else if (timer == TO_MAX) begin
                    // abandon the edit, restore the pre-edit TX state
                    state_nxt   = RUN;
                    tx_en_nxt   = saved_tx;
                    editing_nxt = 1'b0;
                    field_nxt   = 1'b0;
                    timer_nxt   = '0;
                end else begin
                    timer_nxt = timer + TO_W'(1);
                end
            end

            COMMIT: begin
                // cfg_valid is always high here; buttons are ignored
                if (cfg_valid && cfg_ready) begin
                    state_nxt     = RUN;
                    cfg_valid_nxt = 1'b0;
                    tx_en_nxt     = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_bpsk_mode_ctrl.sv
// tb_bpsk_mode_ctrl: directed self-checking bench for bpsk_mode_ctrl.
// Uses NUM_FREQ=8, NUM_PAT=4, TIMEOUT=16.

module tb_bpsk_mode_ctrl;

    logic       clock;
    logic       reset;
    logic       btn_sel;
    logic       btn_up;
    logic       btn_down;
    logic       cfg_ready;
    logic       cfg_valid;
    logic [2:0] cfg_freq;
    logic [1:0] cfg_pat;
    logic       tx_en;
    logic       editing;
    logic       field;

    int vectors;
    int miscompares;

    bpsk_mode_ctrl #(
        .NUM_FREQ (8),
        .FREQ_W   (3),
        .NUM_PAT  (4),
        .PAT_W    (2),
        .TIMEOUT  (16),
        .TO_W     (5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_sel   (btn_sel),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .cfg_ready (cfg_ready),
        .cfg_valid (cfg_valid),
        .cfg_freq  (cfg_freq),
        .cfg_pat   (cfg_pat),
        .tx_en     (tx_en),
        .editing   (editing),
        .field     (field)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v,
                           input logic [2:0] f, input logic [1:0] p,
                           input logic t, input logic e);
        chk({tag, ".valid"}, 32'(cfg_valid), 32'(v));
        chk({tag, ".freq"}, 32'(cfg_freq), 32'(f));
        chk({tag, ".pat"}, 32'(cfg_pat), 32'(p));
        chk({tag, ".tx_en"}, 32'(tx_en), 32'(t));
        chk({tag, ".editing"}, 32'(editing), 32'(e));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // one-cycle pulse on the selected buttons
    task automatic press(input logic s, input logic u, input logic d);
        btn_sel  = s;
        btn_up   = u;
        btn_down = d;
        tick();
        btn_sel  = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        btn_sel     = 1'b0;
        btn_up      = 1'b0;
        btn_down    = 1'b0;
        cfg_ready   = 1'b0;

        tick();
        chk_all("rst", 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
        chk("rst.field", 32'(field), 32'd0);
        reset = 1'b0;
        tick();
        chk_all("run0", 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);

        // up/down ignored in RUN
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk_all("run_ign", 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);

        // basic edit and commit
        cfg_ready = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        chk("t2.edit", 32'(editing), 32'd1);
        chk("t2.field0", 32'(field), 32'd0);
        chk("t2.tx0", 32'(tx_en), 32'd0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("t2.field1", 32'(field), 32'd1);
        chk("t2.edit2", 32'(editing), 32'd1);
        chk("t2.nov", 32'(cfg_valid), 32'd0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        chk_all("t2.commit", 1'b1, 3'd3, 2'd3, 1'b0, 1'b0);
        tick();
        chk_all("t2.done", 1'b0, 3'd3, 2'd3, 1'b1, 1'b0);
        tick();
        chk("t2.valid1cyc", 32'(cfg_valid), 32'd0);

        // async reset mid-run
        #2;
        reset = 1'b1;
        #1;
        chk_all("t1.rst", 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        tick();
        chk_all("t1.run", 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);

        // wrap boundaries: freq 0 -> 7, pat 0 -> 3
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        chk_all("t3.wrapdn", 1'b1, 3'd7, 2'd3, 1'b0, 1'b0);
        tick();
        chk("t3.hs1", 32'(tx_en), 32'd1);

        // freq 7 -> 0, pat 3 -> 0, up+down no change in both fields
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        chk_all("t3.wrapup", 1'b1, 3'd0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("t3.hs2", 1'b0, 3'd0, 2'd0, 1'b1, 1'b0);

        // COMMIT stall: bus held, buttons ignored
        cfg_ready = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk_all("t4.offer", 1'b1, 3'd1, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            press(i == 3, i == 1 || i == 7, i == 5);
            chk_all($sformatf("t4.hold%0d", i), 1'b1, 3'd1, 2'd1,
                    1'b0, 1'b0);
        end
        cfg_ready = 1'b1;
        tick();
        chk_all("t4.hs", 1'b0, 3'd1, 2'd1, 1'b1, 1'b0);

        // commit freq=3 with tx_en=1
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        tick();
        chk_all("t5.base", 1'b0, 3'd3, 2'd1, 1'b1, 1'b0);

        // timeout discards the edit and restores tx_en
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        idle(15);
        chk_all("t5.pre", 1'b0, 3'd3, 2'd1, 1'b0, 1'b1);
        tick();
        chk_all("t5.to", 1'b0, 3'd3, 2'd1, 1'b1, 1'b0);

        // pulse at count 15 restarts the window
        press(1'b1, 1'b0, 1'b0);
        idle(15);
        chk("t5.r.pre", 32'(editing), 32'd1);
        press(1'b0, 1'b1, 1'b0);
        idle(15);
        chk_all("t5.r.hold", 1'b0, 3'd3, 2'd1, 1'b0, 1'b1);
        tick();
        chk_all("t5.r.to", 1'b0, 3'd3, 2'd1, 1'b1, 1'b0);

        // reset withdraws an offered config
        cfg_ready = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk_all("t6.offer", 1'b1, 3'd3, 2'd1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("t6.rst", 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        cfg_ready = 1'b1;
        tick();
        chk_all("t6.run", 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("t6.reedit", 32'(editing), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
